// File: rtl/memshare_skid_buf.sv
// Column-address skid buffer: a two-entry ordered pipe (main + skid register)
// that adds one cycle to any beat tagged as skid and counts skid events.
module memshare_skid_buf #(
  parameter int COL_ADDR_W = 8,
  parameter int SKID_CNT_W = 8
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  flush_i,
  input  logic                  isColAddr_skid_i,
  input  logic [COL_ADDR_W-1:0] col_addr_i,
  input  logic                  col_valid_i,
  output logic                  col_ready_o,
  output logic [COL_ADDR_W-1:0] col_addr_o,
  output logic                  col_valid_o,
  input  logic                  col_ready_i,
  output logic [SKID_CNT_W-1:0] skid_cnt_o,
  output logic                  skid_drop_o
);

  // Encoding is {skid_v, main_v}, so the state bits double as the valid bits.
  typedef enum logic [1:0] {
    ST_EMPTY    = 2'b00,
    ST_MAIN     = 2'b01,
    ST_SKIDONLY = 2'b10,
    ST_FULL     = 2'b11
  } state_t;

  state_t                  state_r;
  state_t                  stateNext_s;
  logic [COL_ADDR_W-1:0]   mainData_r;
  logic [COL_ADDR_W-1:0]   skidData_r;
  logic [SKID_CNT_W-1:0]   skidCnt_r;
  logic                    skidDrop_r;
  logic                    accept_s;
  logic                    drain_s;
  logic                    loadMainIn_s;
  logic                    loadMainSkid_s;
  logic                    loadSkid_s;

  assign col_ready_o = ~state_r[1];
  assign col_valid_o = state_r[0];
  assign col_addr_o  = mainData_r;
  assign skid_cnt_o  = skidCnt_r;
  assign skid_drop_o = skidDrop_r;

  assign accept_s = col_valid_i & col_ready_o;
  assign drain_s  = col_valid_o & col_ready_i;

  // Next-state and register-load selection; flush overrides every transition.
  always_comb begin
    stateNext_s    = state_r;
    loadMainIn_s   = 1'b0;
    loadMainSkid_s = 1'b0;
    loadSkid_s     = 1'b0;
    if (flush_i) begin
      stateNext_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s && isColAddr_skid_i) begin
            loadSkid_s  = 1'b1;
            stateNext_s = ST_SKIDONLY;
          end else if (accept_s) begin
            loadMainIn_s = 1'b1;
            stateNext_s  = ST_MAIN;
          end else begin
            stateNext_s = ST_EMPTY;
          end
        end
        ST_MAIN: begin
          if (drain_s && accept_s && !isColAddr_skid_i) begin
            loadMainIn_s = 1'b1;
            stateNext_s  = ST_MAIN;
          end else if (drain_s && accept_s) begin
            loadSkid_s  = 1'b1;
            stateNext_s = ST_SKIDONLY;
          end else if (drain_s) begin
            stateNext_s = ST_EMPTY;
          end else if (accept_s) begin
            // Main is still occupied, so even a non-skid beat parks in skid.
            loadSkid_s  = 1'b1;
            stateNext_s = ST_FULL;
          end else begin
            stateNext_s = ST_MAIN;
          end
        end
        ST_SKIDONLY: begin
          loadMainSkid_s = 1'b1;
          stateNext_s    = ST_MAIN;
        end
        ST_FULL: begin
          if (drain_s) begin
            loadMainSkid_s = 1'b1;
            stateNext_s    = ST_MAIN;
          end else begin
            stateNext_s = ST_FULL;
          end
        end
        default: begin
          stateNext_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Main and skid data registers.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      mainData_r <= {COL_ADDR_W{1'b0}};
      skidData_r <= {COL_ADDR_W{1'b0}};
    end else begin
      if (loadMainIn_s) begin
        mainData_r <= col_addr_i;
      end else if (loadMainSkid_s) begin
        mainData_r <= skidData_r;
      end else begin
        mainData_r <= mainData_r;
      end
      if (loadSkid_s) begin
        skidData_r <= col_addr_i;
      end else begin
        skidData_r <= skidData_r;
      end
    end
  end

  // Saturating skid-event counter and the registered drop pulse.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      skidCnt_r  <= {SKID_CNT_W{1'b0}};
      skidDrop_r <= 1'b0;
    end else if (flush_i) begin
      skidCnt_r  <= {SKID_CNT_W{1'b0}};
      skidDrop_r <= 1'b0;
    end else begin
      if (accept_s && isColAddr_skid_i && (skidCnt_r != {SKID_CNT_W{1'b1}})) begin
        skidCnt_r <= skidCnt_r + SKID_CNT_W'(1);
      end else begin
        skidCnt_r <= skidCnt_r;
      end
      skidDrop_r <= col_valid_i & isColAddr_skid_i & ~col_ready_o;
    end
  end

endmodule

// File: tb/tb_memshare_skid_buf.sv
// Randomized and directed bench for memshare_skid_buf: an acceptance-order
// scoreboard checked by a monitor, plus occupancy/counter reference model.
module tb_memshare_skid_buf;

  logic       sys_clk = 1'b0;
  logic       rstn;
  logic       flush_i;
  logic       isColAddr_skid_i;
  logic [7:0] col_addr_i;
  logic       col_valid_i;
  logic       col_ready_o;
  logic [7:0] col_addr_o;
  logic       col_valid_o;
  logic       col_ready_i;
  logic [7:0] skid_cnt_o;
  logic       skid_drop_o;

  memshare_skid_buf #(.COL_ADDR_W(8), .SKID_CNT_W(8)) dut (
    .sys_clk          (sys_clk),
    .rstn             (rstn),
    .flush_i          (flush_i),
    .isColAddr_skid_i (isColAddr_skid_i),
    .col_addr_i       (col_addr_i),
    .col_valid_i      (col_valid_i),
    .col_ready_o      (col_ready_o),
    .col_addr_o       (col_addr_o),
    .col_valid_o      (col_valid_o),
    .col_ready_i      (col_ready_i),
    .skid_cnt_o       (skid_cnt_o),
    .skid_drop_o      (skid_drop_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] addr;
    int         cyc;
  } beat_t;

  beat_t expQ[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    expCnt   = 0;
  logic  expDrop  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the falling edge.
  task automatic cycle(input logic v, input logic s, input logic [7:0] a,
                       input logic r, input logic f);
    @(negedge sys_clk);
    col_valid_i      = v;
    isColAddr_skid_i = s;
    col_addr_i       = a;
    col_ready_i      = r;
    flush_i          = f;
    #1;
    cyc++;
    chk("skid_cnt", skid_cnt_o, expCnt);
    chk("skid_drop", skid_drop_o, expDrop);
    if (expQ.size() == 0) begin
      chk("empty_valid", col_valid_o, 0);
      chk("empty_ready", col_ready_o, 1);
    end else if (expQ.size() == 2) begin
      chk("two_held_ready", col_ready_o, 0);
    end else if (expQ.size() > 2) begin
      chk("occupancy", expQ.size(), 2);
    end
    if (expQ.size() > 0 && (cyc - expQ[0].cyc) >= 2) begin
      chk("head_visible", col_valid_o, 1);
    end
    expDrop = v & s & ~col_ready_o & ~f;
    if (f) begin
      expQ.delete();
      expCnt = 0;
    end else if (v && col_ready_o) begin
      expQ.push_back('{a, cyc});
      if (s && expCnt < 255) expCnt++;
    end
  endtask

  // Scoreboard monitor: every handshaken output beat must be the oldest accepted one.
  initial begin
    forever begin
      @(negedge sys_clk);
      #2;
      if (rstn && col_valid_o && col_ready_i) begin
        if (expQ.size() == 0) begin
          chk("unexpected_beat", col_addr_o, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = expQ.pop_front();
          chk("data_order", col_addr_o, b.addr);
        end
      end
    end
  end

  task automatic t1();
    cycle(1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
    chk("t1_valid0", col_valid_o, 1);
    chk("t1_addr0", col_addr_o, 8'h11);
    cycle(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
    chk("t1_addr1", col_addr_o, 8'h22);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_addr2", col_addr_o, 8'h33);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_empty", col_valid_o, 0);
  endtask

  initial begin
    rstn = 1'b0;
    flush_i = 1'b0;
    isColAddr_skid_i = 1'b0;
    col_addr_i = 8'h00;
    col_valid_i = 1'b0;
    col_ready_i = 1'b0;
    #12;
    chk("rst_valid", col_valid_o, 0);
    chk("rst_ready", col_ready_o, 1);
    chk("rst_cnt", skid_cnt_o, 0);
    chk("rst_drop", skid_drop_o, 0);
    @(negedge sys_clk);
    rstn = 1'b1;

    t1();

    // Skid beat into an empty buffer: inserted cycle, then visible.
    cycle(1'b1, 1'b1, 8'h40, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_ready", col_ready_o, 0);
    chk("t2_valid_early", col_valid_o, 0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_valid", col_valid_o, 1);
    chk("t2_addr", col_addr_o, 8'h40);
    chk("t2_cnt", skid_cnt_o, 1);

    // Backpressure fills both registers; skid request while full is a drop.
    cycle(1'b1, 1'b0, 8'hA0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
    chk("t3_full_ready", col_ready_o, 0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_drop", skid_drop_o, 1);
    chk("t4_cnt", skid_cnt_o, 1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_drop_clear", skid_drop_o, 0);
    chk("t3_head", col_addr_o, 8'hA0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_second", col_addr_o, 8'hA1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Counter saturation, then flush.
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 700 && expCnt < 255; i++) begin
      cycle(1'b1, 1'b1, 8'(i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'(i), 1'b1, 1'b0);
    chk("t5_sat", skid_cnt_o, 8'hFF);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_flush_cnt", skid_cnt_o, 0);
    chk("t5_flush_valid", col_valid_o, 0);

    // Asynchronous reset while full.
    cycle(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_full", col_ready_o, 0);
    rstn = 1'b0;
    #1;
    chk("t6_valid", col_valid_o, 0);
    chk("t6_ready", col_ready_o, 1);
    chk("t6_cnt", skid_cnt_o, 0);
    chk("t6_drop", skid_drop_o, 0);
    expQ.delete();
    expCnt = 0;
    expDrop = 1'b0;
    @(negedge sys_clk);
    rstn = 1'b1;
    t1();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      logic f;
      f = ($urandom_range(0, 39) == 0);
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            8'($urandom_range(0, 255)), f ? 1'b0 : 1'($urandom_range(0, 2) != 0), f);
    end

    // Drain whatever is left, bounded.
    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("final_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
